// File: rtl/hadamard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hadamard_pkg
// Description : Shared definitions for the hadamard4_arb block. Holds the
//               datapath depth, the controller state encoding and the
//               round-robin search helper used by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package hadamard_pkg;

    // Number of enabled datapath cycles per transaction (ST1 + ST2).
    localparam int DP_LATENCY = 2;

    // Widest requester vector the round-robin helper searches.
    localparam int RR_MAX = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST1    = 2'd1,
        ST2    = 2'd2,
        RESULT = 2'd3
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid, searching from ptr upward and wrapping at nreq.
    // Bits at or above nreq are never considered.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0] valid,
        input logic [2:0]        ptr,
        input int                nreq
    );
        rr_pick_t r;
        int       cand;
        r.found = 1'b0;
        r.idx   = 3'd0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < nreq) begin
                cand = (int'(ptr) + k) % nreq;
                if (!r.found && valid[cand]) begin
                    r.found = 1'b1;
                    r.idx   = 3'(cand);
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hadamard4_dp.sv
`default_nettype none
// ============================================================================
// Module      : hadamard4_dp
// Description : Two-stage 4-point Hadamard adder/subtractor pipeline.
//               Both stages load only while dp_en is high; with dp_en low
//               the outputs hold. No reset: contents are meaningful only
//               after two enabled cycles.
// Ports       : clk   - clock, rising edge
//               dp_en - stage load enable
//               x     - four signed DW-bit samples, xk at [k*DW +: DW]
//               y     - four signed DW+2-bit results, yk at [k*(DW+2) +: DW+2]
// Revision    : 1.0 - initial release
// ============================================================================
module hadamard4_dp #(
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                dp_en,
    input  logic [4*DW-1:0]     x,
    output logic [4*(DW+2)-1:0] y
);

    logic signed [DW-1:0] w_x  [4];
    logic signed [DW:0]   w_xe [4];
    logic signed [DW:0]   r_a  [4];
    logic signed [DW+1:0] w_ae [4];
    logic signed [DW+1:0] r_y  [4];

    // Each stage grows by one bit, so sign extension before the add makes
    // overflow impossible.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_x[k]  = x[k*DW +: DW];
        assign w_xe[k] = {w_x[k][DW-1], w_x[k]};
        assign w_ae[k] = {r_a[k][DW], r_a[k]};
        assign y[k*(DW+2) +: DW+2] = r_y[k];
    end

    // Both stages share one enable: in the first enabled cycle stage 2 loads
    // stale data, in the second stage 1 reloads the same (unchanged) input
    // while stage 2 captures the correct result.
    always_ff @(posedge clk) begin
        if (dp_en) begin
            r_a[0] <= w_xe[0] + w_xe[1];
            r_a[1] <= w_xe[2] + w_xe[3];
            r_a[2] <= w_xe[0] - w_xe[1];
            r_a[3] <= w_xe[2] - w_xe[3];
            r_y[0] <= w_ae[0] + w_ae[1];
            r_y[1] <= w_ae[2] + w_ae[3];
            r_y[2] <= w_ae[0] - w_ae[1];
            r_y[3] <= w_ae[2] - w_ae[3];
        end
    end

endmodule
`default_nettype wire

// File: rtl/hadamard4_arb.sv
`default_nettype none
// ============================================================================
// Module      : hadamard4_arb
// Description : Round-robin scheduler sharing one two-stage 4-point Hadamard
//               datapath among NREQ requesters. One transaction in flight.
// Ports       : clk, rst  - clock (rising), asynchronous active-high reset
//               req_valid - per-requester vector valid
//               req_ready - per-requester accept, one-hot or zero
//               req_data  - requester i at [i*4*DW +: 4*DW]
//               out_valid - result valid, out_ready - consumer accept
//               out_tag   - index of the requester owning the result
//               out_y     - four signed DW+2-bit results
//               busy      - high whenever the controller is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module hadamard4_arb
    import hadamard_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int TW   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*4*DW-1:0]   req_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TW-1:0]          out_tag,
    output logic [4*(DW+2)-1:0]    out_y,
    output logic                   busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TW-1:0]     r_rr_ptr;
    logic [TW-1:0]     r_tag;
    logic [4*DW-1:0]   r_xreg;
    logic [RR_MAX-1:0] w_valid_ext;
    rr_pick_t          w_pick;
    logic              w_hs;
    logic              w_dp_en;
    logic [2:0]        w_ptr_nxt;
    logic [4*DW-1:0]   w_sel_data;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    always_comb begin
        w_valid_ext = '0;
        w_valid_ext[NREQ-1:0] = req_valid;
    end

    assign w_pick = rr_pick(w_valid_ext, 3'(r_rr_ptr), NREQ);

    // A grant in IDLE is always a handshake: ready is only raised for a
    // requester that is currently valid.
    assign w_hs = (r_state == IDLE) && w_pick.found;

    assign w_ptr_nxt = (w_pick.idx == 3'(NREQ-1)) ? 3'd0 : w_pick.idx + 3'd1;

    // rst gates ready so no requester sees an accept while reset is held,
    // even though the state register already reads IDLE.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_hs && !rst && (w_pick.idx == 3'(i));
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick.idx == 3'(i)) begin
                w_sel_data = req_data[i*4*DW +: 4*DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_tag    <= '0;
            r_xreg   <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= TW'(w_ptr_nxt);
            r_tag    <= TW'(w_pick.idx);
            r_xreg   <= w_sel_data;
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM: ST1 and ST2 are the DP_LATENCY enabled cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dp_en     = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_nxt = ST1;
                end
            end
            ST1: begin
                w_dp_en     = 1'b1;
                w_state_nxt = ST2;
            end
            ST2: begin
                w_dp_en     = 1'b1;
                w_state_nxt = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = (r_state != IDLE);
    assign out_tag = r_tag;

    // ------------------------------------------------------------------
    // Shared datapath
    // ------------------------------------------------------------------
    hadamard4_dp #(
        .DW(DW)
    ) u_dp (
        .clk   (clk),
        .dp_en (w_dp_en),
        .x     (r_xreg),
        .y     (out_y)
    );

endmodule
`default_nettype wire

// File: tb/tb_hadamard4_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hadamard4_arb
// Description : Self-checking bench for hadamard4_arb. A reference model
//               predicts grants, timing and results; an output monitor
//               compares every delivered result against the expected queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hadamard4_arb;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int TW   = 1;
    localparam int YW   = DW + 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*4*DW-1:0] req_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [TW-1:0]        out_tag;
    logic [4*YW-1:0]      out_y;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int tag;
        int y0;
        int y1;
        int y2;
        int y3;
    } exp_t;

    exp_t exp_q[$];
    int   tag_hist[$];
    int   tag1_cnt = 0;

    // Hadamard sign matrix: row r gives the signs applied to x0..x3 for yr.
    int H [4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};

    hadamard4_arb #(
        .NREQ(NREQ),
        .DW  (DW),
        .TW  (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_tag  (out_tag),
        .out_y    (out_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int samp(input int i, input int k);
        logic signed [DW-1:0] v;
        v = req_data[i*4*DW + k*DW +: DW];
        return int'(v);
    endfunction

    function automatic int href(input int i, input int r);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += H[r][k] * samp(i, k);
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: transaction-level timing (grant, two compute
    // cycles, result held until accepted) and round-robin choice.
    // ------------------------------------------------------------------
    int m_phase = 0;
    int m_ptr   = 0;

    always @(negedge clk) begin
        int   g;
        exp_t e;
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            exp_q.delete();
            chk("ready_in_rst", longint'(req_ready), 0);
            chk("valid_in_rst", longint'(out_valid), 0);
        end else begin
            chk("out_valid", longint'(out_valid), longint'(m_phase == 3));
            chk("busy", longint'(busy), longint'(m_phase != 0));
            if (m_phase == 0) begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
                if (g >= 0) begin
                    chk("grant", longint'(req_ready), longint'(1 << g));
                    e.tag = g;
                    e.y0  = href(g, 0);
                    e.y1  = href(g, 1);
                    e.y2  = href(g, 2);
                    e.y3  = href(g, 3);
                    exp_q.push_back(e);
                    m_ptr   = (g + 1) % NREQ;
                    m_phase = 1;
                end else begin
                    chk("idle_ready", longint'(req_ready), 0);
                end
            end else begin
                chk("busy_ready", longint'(req_ready), 0);
                if (m_phase < 3) m_phase++;
                else if (out_ready) m_phase = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    logic            held = 1'b0;
    logic [4*YW-1:0] h_y;
    logic [TW-1:0]   h_tag;

    function automatic longint ys(input int k);
        logic signed [YW-1:0] v;
        v = out_y[k*YW +: YW];
        return longint'(v);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (held) begin
                chk("hold_y", longint'(out_y), longint'(h_y));
                chk("hold_tag", longint'(out_tag), longint'(h_tag));
            end
            if (out_ready) begin
                held = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: got tag %0d expected no result", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_tag", longint'(out_tag), e.tag);
                    chk("res_y0", ys(0), e.y0);
                    chk("res_y1", ys(1), e.y1);
                    chk("res_y2", ys(2), e.y2);
                    chk("res_y3", ys(3), e.y3);
                    tag_hist.push_back(int'(out_tag));
                    if (out_tag == 1) tag1_cnt++;
                end
            end else begin
                held  = 1'b1;
                h_y   = out_y;
                h_tag = out_tag;
            end
        end else begin
            held = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int i, input int x0, input int x1, input int x2, input int x3);
        int xs[4];
        xs = '{x0, x1, x2, x3};
        for (int k = 0; k < 4; k++) req_data[i*4*DW + k*DW +: DW] = xs[k][DW-1:0];
    endtask

    task automatic send(input int i);
        int n;
        n = 0;
        req_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 40);
        if (!req_ready[i]) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: requester %0d got no ready, expected ready", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: out_valid 0 expected 1", nm);
        end
    endtask

    task automatic expect_result(input int t, input int y0, input int y1, input int y2, input int y3);
        wait_valid("dir");
        chk("dir_tag", longint'(out_tag), t);
        chk("dir_y0", ys(0), y0);
        chk("dir_y1", ys(1), y1);
        chk("dir_y2", ys(2), y2);
        chk("dir_y3", ys(3), y3);
        @(posedge clk);
        #1;
    endtask

    int t1_before;

    initial begin
        // Reset: ready must stay low even with requests pending.
        req_valid = 2'b11;
        cyc(3);
        chk("rst_ready_direct", longint'(req_ready), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        req_valid = '0;
        rst = 1'b0;
        cyc(1);

        // Single request and signed extremes.
        set_x(0, 10, 20, 30, 40);
        send(0);
        expect_result(0, 100, -20, -40, 0);
        set_x(1, -128, -128, -128, -128);
        send(1);
        expect_result(1, -512, 0, 0, 0);
        set_x(0, 127, -128, 127, -128);
        send(0);
        expect_result(0, -2, 510, 0, 0);
        cyc(2);

        // Fairness from a fresh pointer: both requesters always valid.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        tag_hist.delete();
        req_valid = 2'b11;
        for (int c = 0; c < 24; c++) begin
            req_data = {$urandom, $urandom};
            cyc(1);
        end
        req_valid = '0;
        cyc(6);
        chk("fair_count", longint'(tag_hist.size() >= 4), 1);
        for (int k = 0; k < 4 && k < tag_hist.size(); k++) chk("fair_tag", tag_hist[k], k % 2);

        // Backpressure: result held for 10 cycles with requests pending.
        out_ready = 1'b0;
        req_data  = {$urandom, $urandom};
        req_valid = 2'b11;
        wait_valid("bp");
        cyc(10);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_grant", longint'(req_ready != 0), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        cyc(6);

        // Reset during ST2 drops the transaction and clears the pointer.
        set_x(0, $urandom_range(0, 255), 5, -7, 9);
        send(0);
        cyc(1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        cyc(2);
        rst = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        chk("midrst_grant0", longint'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        cyc(6);

        // Withdrawn request while busy is never granted.
        t1_before = tag1_cnt;
        set_x(0, 1, 2, 3, 4);
        send(0);
        req_valid[1] = 1'b1;
        cyc(1);
        req_valid[1] = 1'b0;
        cyc(8);
        chk("withdrawn_tag1", tag1_cnt, t1_before);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom_range(0, 3));
            req_data  = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        req_valid = '0;
        out_ready = 1'b1;
        cyc(10);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
